// File: rtl/bch1572_seq_decoder.sv
// Serial BCH(15,7) t=2 decoder: Horner syndromes, Peterson solve, Chien search.
// One codeword in flight; results are held until the consumer accepts them.
module bch1572_seq_decoder #(
    parameter int unsigned DATA_WIDTH   = 7,
    parameter int unsigned CODE_WIDTH   = 15,
    parameter int unsigned PARITY_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_WIDTH-1:0] codeword_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error_detected,
    output logic                  error_corrected,
    output logic                  uncorrectable,
    output logic [3:0]            error_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    if (DATA_WIDTH != 7) begin : g_bad_data_width
        $error("DATA_WIDTH must be 7");
    end
    if (CODE_WIDTH != 15) begin : g_bad_code_width
        $error("CODE_WIDTH must be 15");
    end
    if (PARITY_WIDTH != 8) begin : g_bad_parity_width
        $error("PARITY_WIDTH must be 8");
    end

    localparam logic [3:0] LastIdx = 4'd14;

    typedef enum logic [2:0] {StIdle, StSynd, StSolve, StChien, StDone} state_t;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        case (a)
            4'h1: return 4'h1;  4'h2: return 4'h9;  4'h3: return 4'hE;  4'h4: return 4'hD;
            4'h5: return 4'hB;  4'h6: return 4'h7;  4'h7: return 4'h6;  4'h8: return 4'hF;
            4'h9: return 4'h2;  4'hA: return 4'hC;  4'hB: return 4'h5;  4'hC: return 4'hA;
            4'hD: return 4'h4;  4'hE: return 4'h3;  4'hF: return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    state_t                r_state, w_state_next;
    logic [CODE_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_orig_data;
    logic [3:0]            r_idx, r_s1, r_s3, r_t1, r_t2, r_cnt;
    logic [1:0]            r_nerr;
    logic                  r_fail;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_detected, r_corrected, r_uncorr;
    logic [3:0]            r_count;

    logic [3:0]            w_s1_sq, w_s1_cube, w_sig1, w_sig2, w_cnt_next;
    logic [1:0]            w_nerr;
    logic                  w_fail, w_hit, w_fix_en, w_ok;
    logic [CODE_WIDTH-1:0] w_flip_mask, w_word_fixed;

    // Peterson solution for t=2 from the finished syndromes.
    always_comb begin
        w_s1_sq   = gf_mul(r_s1, r_s1);
        w_s1_cube = gf_mul(w_s1_sq, r_s1);
        w_sig1    = 4'h0;
        w_sig2    = 4'h0;
        w_nerr    = 2'd0;
        w_fail    = 1'b0;
        if (r_s1 == 4'h0) begin
            w_fail = (r_s3 != 4'h0);
        end else if (r_s3 == w_s1_cube) begin
            w_nerr = 2'd1;
            w_sig1 = r_s1;
        end else begin
            w_nerr = 2'd2;
            w_sig1 = r_s1;
            w_sig2 = gf_mul(r_s3, gf_inv(r_s1)) ^ w_s1_sq;
        end
    end

    // Chien step for position r_idx; the last step's flip is folded into the result.
    assign w_hit        = ((4'h1 ^ r_t1 ^ r_t2) == 4'h0);
    assign w_fix_en     = !r_fail && (r_nerr != 2'd0);
    assign w_flip_mask  = (w_hit && w_fix_en) ? (CODE_WIDTH'(1) << r_idx) : '0;
    assign w_word_fixed = r_word ^ w_flip_mask;
    assign w_cnt_next   = r_cnt + {3'b000, w_hit};
    assign w_ok         = !r_fail && (w_cnt_next == {2'b00, r_nerr});

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = StSynd;
            end
            StSynd:  if (r_idx == 4'd0) w_state_next = StSolve;
            StSolve: w_state_next = StChien;
            StChien: if (r_idx == LastIdx) w_state_next = StDone;
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_orig_data <= '0;
            r_idx       <= 4'd0;
            r_s1        <= 4'h0;
            r_s3        <= 4'h0;
            r_t1        <= 4'h0;
            r_t2        <= 4'h0;
            r_cnt       <= 4'd0;
            r_nerr      <= 2'd0;
            r_fail      <= 1'b0;
            r_data      <= '0;
            r_detected  <= 1'b0;
            r_corrected <= 1'b0;
            r_uncorr    <= 1'b0;
            r_count     <= 4'd0;
        end else begin
            case (r_state)
                StIdle: if (in_valid) begin
                    r_word      <= codeword_in;
                    r_orig_data <= codeword_in[CODE_WIDTH-1 -: DATA_WIDTH];
                    r_s1        <= 4'h0;
                    r_s3        <= 4'h0;
                    r_idx       <= LastIdx;
                end
                StSynd: begin
                    r_s1  <= gf_mul(r_s1, 4'h2) ^ {3'b000, r_word[r_idx]};
                    r_s3  <= gf_mul(r_s3, 4'h8) ^ {3'b000, r_word[r_idx]};
                    r_idx <= r_idx - 4'd1;
                end
                StSolve: begin
                    r_t1   <= w_sig1;
                    r_t2   <= w_sig2;
                    r_nerr <= w_nerr;
                    r_fail <= w_fail;
                    r_idx  <= 4'd0;
                    r_cnt  <= 4'd0;
                end
                StChien: begin
                    r_word <= w_word_fixed;
                    r_cnt  <= w_cnt_next;
                    r_t1   <= gf_mul(r_t1, 4'h9);
                    r_t2   <= gf_mul(r_t2, 4'hD);
                    r_idx  <= r_idx + 4'd1;
                    if (r_idx == LastIdx) begin
                        r_detected  <= (r_s1 | r_s3) != 4'h0;
                        r_uncorr    <= !w_ok;
                        r_corrected <= w_ok && (r_nerr != 2'd0);
                        r_count     <= w_ok ? {2'b00, r_nerr} : 4'd0;
                        r_data      <= w_ok ? w_word_fixed[CODE_WIDTH-1 -: DATA_WIDTH]
                                            : r_orig_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out        = r_data;
    assign error_detected  = r_detected;
    assign error_corrected = r_corrected;
    assign uncorrectable   = r_uncorr;
    assign error_count     = r_count;

endmodule
